// File: rtl/uart_txfsm_gen_if.sv
// TX FIFO read port seen by the UART transmit engine.
//
// Handshake: fifo_data is valid whenever fifo_empty is low (first-word
// fall-through). The engine pulses fifo_rd high for exactly one cycle to pop
// the head entry; it only does so after sampling fifo_empty low, and never
// more than once per character.
interface uart_txfsm_gen_if #(
   parameter int DATA_W = 9
);
   logic              fifo_empty;
   logic              fifo_rd;
   logic [DATA_W-1:0] fifo_data;

   // Transmit engine side: consumes data, issues the pop.
   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd
   );

   // FIFO side: presents the head entry, receives the pop.
   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd
   );
endinterface

// File: rtl/uart_txfsm_gen.sv
// Parametrised UART transmit engine.
// Pulls characters from a first-word-fall-through TX FIFO and serialises them
// onto the txd line: start bit, 5..DATA_W data bits LSB first, optional
// even/odd/mark/space parity, then 1, 1.5 or 2 stop bits. Also generates a
// line break on request and reports busy/done status.
// Every state change and so update happens on a divider tick (one per bit
// period of OVS clocks). The only exception is 1.5 stop bits, where the
// divider is preloaded to OVS/2 on entry to STOP2 so that the second stop
// period is half a bit long.
module uart_txfsm_gen #(
   parameter int DATA_W = 9,
   parameter int OVS    = 16,
   parameter int CNT_W  = $clog2(OVS)
) (
   input  logic                    baud_clk_16x,
   input  logic                    reset_n,
   input  logic                    cfg_tx_enable,
   input  logic [3:0]              cfg_char_len,
   input  logic [1:0]              cfg_stop_bit,
   input  logic [2:0]              cfg_pri_mod,
   input  logic                    cfg_break,
   uart_txfsm_gen_if.master        fifo,
   output logic                    tx_busy,
   output logic                    tx_done,
   output logic                    so,
   output logic [2:0]              dbg_state
);

   // Character length is carried in 4 bits, so DATA_W is at most 15.
   localparam logic [3:0]       LEN_MIN  = 4'd5;
   localparam logic [3:0]       LEN_MAX  = 4'(DATA_W);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(OVS - 1);
   localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(OVS / 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP1 = 3'd4,
      S_STOP2 = 3'd5,
      S_BREAK = 3'd6
   } state_t;

   // Registered state and outputs.
   state_t              state_q,   state_d;
   logic                so_q,      so_d;
   logic                fifo_rd_q, fifo_rd_d;
   logic                tx_done_q, tx_done_d;
   logic [CNT_W-1:0]    divcnt_q,  divcnt_d;
   logic [3:0]          bitcnt_q,  bitcnt_d;
   logic [DATA_W-1:0]   shift_q,   shift_d;

   // Per-frame configuration captured when the start bit begins, so that
   // configuration writes mid-frame only affect the next character.
   logic [3:0]          len_q,     len_d;
   logic [1:0]          stop_q,    stop_d;
   logic                par_en_q,  par_en_d;
   logic                par_bit_q, par_bit_d;

   // Set while the mark period after a break is being sent through STOP1;
   // that exit behaves as a single stop bit and raises no tx_done.
   logic                brk_q,     brk_d;

   // Helpers for the frame-load decision.
   logic                tick;
   logic                eval_idle;
   logic [3:0]          len_eff;
   logic [DATA_W-1:0]   data_mask;
   logic [DATA_W-1:0]   data_masked;
   logic                par_bit_new;

   // End of the current bit period.
   assign tick = (divcnt_q == DIV_LAST);

   // Clamp the requested character length into 5..DATA_W.
   always_comb begin
      len_eff = cfg_char_len;
      if (cfg_char_len < LEN_MIN) begin
         len_eff = LEN_MIN;
      end else if (cfg_char_len > LEN_MAX) begin
         len_eff = LEN_MAX;
      end
   end

   // Keep only the low len_eff bits of the FIFO head.
   always_comb begin
      data_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         data_mask[i] = (i < int'(len_eff));
      end
   end

   assign data_masked = fifo.fifo_data & data_mask;

   // Parity bit for the character about to be loaded; upper bit of
   // cfg_pri_mod enables parity, lower bits pick even/odd/mark/space.
   always_comb begin
      par_bit_new = 1'b0;
      case (cfg_pri_mod[1:0])
         2'b00:   par_bit_new = ^data_masked;
         2'b01:   par_bit_new = ~(^data_masked);
         2'b10:   par_bit_new = 1'b1;
         default: par_bit_new = 1'b0;
      endcase
   end

   // Next-state, divider and output logic of the transmit FSM.
   always_comb begin
      state_d   = state_q;
      so_d      = so_q;
      fifo_rd_d = 1'b0;
      tx_done_d = 1'b0;
      divcnt_d  = tick ? '0 : divcnt_q + 1'b1;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      len_d     = len_q;
      stop_d    = stop_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      brk_d     = brk_q;
      eval_idle = 1'b0;

      if (tick) begin
         case (state_q)
            S_IDLE: begin
               eval_idle = 1'b1;
            end

            S_START: begin
               state_d  = S_DATA;
               so_d     = shift_q[0];
               shift_d  = shift_q >> 1;
               bitcnt_d = 4'd1;
            end

            S_DATA: begin
               if (bitcnt_q < len_q) begin
                  so_d     = shift_q[0];
                  shift_d  = shift_q >> 1;
                  bitcnt_d = bitcnt_q + 1'b1;
               end else if (par_en_q) begin
                  state_d = S_PAR;
                  so_d    = par_bit_q;
               end else begin
                  state_d = S_STOP1;
                  so_d    = 1'b1;
               end
            end

            S_PAR: begin
               state_d = S_STOP1;
               so_d    = 1'b1;
            end

            S_STOP1: begin
               if (brk_q) begin
                  brk_d     = 1'b0;
                  eval_idle = 1'b1;
               end else if (stop_q == 2'b00) begin
                  tx_done_d = 1'b1;
                  eval_idle = 1'b1;
               end else begin
                  state_d = S_STOP2;
                  so_d    = 1'b1;
                  if (stop_q == 2'b01) begin
                     divcnt_d = DIV_HALF;
                  end
               end
            end

            S_STOP2: begin
               tx_done_d = 1'b1;
               eval_idle = 1'b1;
            end

            S_BREAK: begin
               // so is held low for as long as the break is requested.
               if (!cfg_break) begin
                  state_d = S_STOP1;
                  so_d    = 1'b1;
                  brk_d   = 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
               so_d    = 1'b1;
            end
         endcase
      end

      // IDLE decision, shared by IDLE itself and by the stop-bit exits so
      // that a queued character starts with no idle gap.
      if (eval_idle) begin
         if (cfg_break) begin
            state_d = S_BREAK;
            so_d    = 1'b0;
         end else if (!fifo.fifo_empty) begin
            state_d   = S_START;
            so_d      = 1'b0;
            fifo_rd_d = 1'b1;
            shift_d   = data_masked;
            len_d     = len_eff;
            stop_d    = cfg_stop_bit;
            par_en_d  = cfg_pri_mod[2];
            par_bit_d = par_bit_new;
         end else begin
            state_d = S_IDLE;
            so_d    = 1'b1;
         end
      end

      // Disabled: hold everything at its reset value, abandoning any frame.
      if (!cfg_tx_enable) begin
         state_d   = S_IDLE;
         so_d      = 1'b1;
         fifo_rd_d = 1'b0;
         tx_done_d = 1'b0;
         divcnt_d  = '0;
         bitcnt_d  = '0;
         shift_d   = '0;
         brk_d     = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge baud_clk_16x or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         so_q      <= 1'b1;
         fifo_rd_q <= 1'b0;
         tx_done_q <= 1'b0;
         divcnt_q  <= '0;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         len_q     <= LEN_MIN;
         stop_q    <= 2'b00;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         brk_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         so_q      <= so_d;
         fifo_rd_q <= fifo_rd_d;
         tx_done_q <= tx_done_d;
         divcnt_q  <= divcnt_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         len_q     <= len_d;
         stop_q    <= stop_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         brk_q     <= brk_d;
      end
   end

   assign so           = so_q;
   assign tx_done      = tx_done_q;
   assign tx_busy      = (state_q != S_IDLE);
   assign fifo.fifo_rd = fifo_rd_q;
   assign dbg_state    = state_q;

endmodule

// File: doc/uart_txfsm_gen.md
Name: uart_txfsm_gen

Overview:
Parametrised UART transmit engine that serialises characters from a first-word-fall-through TX FIFO onto the txd line. It supersedes the fixed 8-bit, 16x transmitter with the following additions:
- configurable character length
- generic oversample ratio
- mark/space parity
- 1.5 stop bits
- break generation
- busy/done status
It sits between the TX FIFO and the pad mux inside the UART core.

Parameters:
DATA_W, 9, maximum character width in bits; fifo_data width.
OVS, 16, baud_clk_16x cycles per bit period; even, 8..32.
CNT_W, $clog2(OVS), width of the bit-period divider.

Ports:
baud_clk_16x  input  1  oversample clock; the only clock.
reset_n  input  1  asynchronous active-low reset.
cfg_tx_enable  input  1  0 = synchronous clear to IDLE, so=1.
cfg_char_len  input  4  data bits per character, 5..DATA_W. Values below 5 act as 5; values above DATA_W act as DATA_W.
cfg_stop_bit  input  2  00=1 stop, 01=1.5 stop, 1x=2 stop.
cfg_pri_mod  input  3  0xx=none, 100=even, 101=odd, 110=mark(1), 111=space(0).
cfg_break  input  1  request break (so held low).
fifo_empty  input  1  TX FIFO empty.
fifo_rd  output  1  one-cycle FIFO pop.
fifo_data  input  DATA_W  FIFO head data; valid while fifo_empty=0.
tx_busy  output  1  high in any state other than IDLE.
tx_done  output  1  one-cycle pulse at end of each character's last stop bit.
so  output  1  txd line.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, so=1, fifo_rd=0, tx_busy=0, tx_done=0, divcnt=0, bitcnt=0, shift register=0.
- cfg_tx_enable=0: same values are loaded synchronously every cycle; this aborts any frame in progress with no tx_done.
- Divider: divcnt increments modulo OVS while enabled. A "tick" is divcnt==OVS-1. All state transitions and so updates occur on ticks only, except in STOP2 for 1.5 stop bits (below).
- States:
  - IDLE, START, DATA, PAR, STOP1, STOP2, BREAK.
  - so is registered and changes on the same edge as the state.
- IDLE, on tick:
  - If cfg_break=1: go to BREAK, so<=0.
  - Else if fifo_empty=0: go to START, so<=0, fifo_rd<=1 for exactly one cycle. On that same edge, latch fifo_data masked to cfg_char_len bits, and latch cfg_char_len, cfg_pri_mod and cfg_stop_bit.
  - Configuration changes mid-frame have no effect until the next frame.
  - Otherwise so stays 1.
- START, on tick: go to DATA, so<=data[0], bitcnt<=1.
- DATA, on tick:
  - If bitcnt<len: so<=data[bitcnt], bitcnt++.
  - Else: go to PAR if parity is enabled, otherwise go to STOP1 with so<=1.
  - Bits are sent LSB first.
- PAR: the parity bit is driven on entry to PAR.
  - Even: XOR of the len data bits.
  - Odd: inverse of even.
  - Mark: 1. Space: 0.
  - On tick: go to STOP1, so<=1.
- STOP1, on tick:
  - 1 stop: go to IDLE and pulse tx_done.
  - Otherwise: go to STOP2, so=1. For 1.5 stop, load divcnt<=OVS/2 on entry so that STOP2 lasts OVS/2 cycles.
- STOP2, on tick: go to IDLE and pulse tx_done.
- Back-to-back characters: IDLE evaluates on the same tick that ends the stop bit. Because IDLE-entry and the IDLE decision coincide, the next start bit begins immediately with zero idle gap. This is implemented by evaluating the IDLE conditions in the STOP1/STOP2 exit branch.
- BREAK:
  - so=0 while cfg_break=1.
  - On a tick with cfg_break=0: go to STOP1 (so<=1), forcing at least one mark bit period. Exit completes via STOP1 as for a 1-stop frame but without tx_done.
  - cfg_break asserted mid-character is ignored until the frame completes.
- fifo_rd never asserts when fifo_empty=1 and never asserts twice per frame.
- Frame length in cycles = OVS × (1 + len + parity_en + stop), with stop ∈ {1, 1.5, 2}.

Test Plan:
- OVS=16, 8N1, fifo_data=0xA5 -> one fifo_rd pulse; so=0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_done pulses at cycle 160; tx_busy high for 160 cycles.
- len=7, even parity, fifo_data=0x35 -> data bits 1,0,1,0,1,1,0; parity=0; 1 stop; frame length 160 cycles.
- 8 data bits, mark parity, 1.5 stop, 0x00 -> parity bit=1; stop period 24 cycles; frame length 184 cycles; with 2 stop (cfg_stop_bit=10) it is 192 cycles.
- Two entries in FIFO, 8N2 -> second start bit falls on the cycle the first frame's second stop ends; exactly 2 fifo_rd pulses; 2 tx_done pulses 176 cycles apart.
- cfg_break=1 asserted mid-character -> character completes normally, then so=0 until cfg_break drops; then at least 16 cycles of so=1; no tx_done for the break.
- cfg_tx_enable dropped during DATA -> so=1 and tx_busy=0 one cycle later, no tx_done; re-enabling with a non-empty FIFO starts a fresh frame on the next tick. reset_n pulsed mid-frame -> immediate so=1 and all outputs at reset values.
